case_6_mul_pipe_sat: RTL and testbench
======================================

# case_6_mul_pipe_sat

Parametrised, pipelined signed/unsigned multiplier with valid/ready flow control and fixed-point output narrowing. It replaces the purely combinational `mul` cores where a multiply must meet timing across one or more register stages, or where the consumer can stall. It sits between scheduled datapath operands and the accumulator or writeback logic in generated `case_*` kernels.

## Interface
- `din0_WIDTH`, 14: width of operand A.
- `din1_WIDTH`, 12: width of operand B.
- `dout_WIDTH`, 26: output width after shift and narrowing.
- `NUM_STAGE`, 2: register stages, input to output; legal range 1..4.
- `SHIFT`, 0: arithmetic right shift applied to the full product before narrowing; range 0..(din0_WIDTH+din1_WIDTH-1).
- `SIGNED0` / `SIGNED1`, 1 / 1: 1 treats the operand as two's complement, 0 as unsigned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; 0 freezes all state.
- `din0`  in  din0_WIDTH  operand A.
- `din1`  in  din1_WIDTH  operand B.
- `din_valid`  in  1  operands are valid this cycle.
- `din_ready`  out  1  block accepts operands this cycle.
- `dout`  out  dout_WIDTH  narrowed product.
- `dout_valid`  out  1  `dout` holds a result.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `dout_sat`  out  1  result was clamped; travels with `dout`.

## Operation
- Full product P is din0_WIDTH+din1_WIDTH bits. Each operand is sign- or zero-extended per its SIGNED parameter. P is signed if either operand is signed.
- Q = P >>> SHIFT. The shift is arithmetic and truncating (floor), with no rounding.
- Narrowing Q to dout_WIDTH:
  - Without the saturation feature, keep the low dout_WIDTH bits (wrap).
  - With it, clamp to the representable range (see Configuration).
- Pipeline advance: `adv = ce & (~dout_valid | dout_ready)`. The whole pipeline shifts only when `adv` is 1.
- `din_ready = adv`. A transfer occurs when `din_valid & din_ready`.
- Stage valid bits form a NUM_STAGE-deep shift register. Each stage's data register loads only when `adv` is 1. Bubbles are not collapsed.
- Multiply is in stage 1. Shift, narrow and saturate are in the last stage.

## Timing
- Latency is exactly NUM_STAGE `adv` cycles from input transfer to `dout_valid`.
- Throughput is one result per cycle while `dout_ready` = 1 and `ce` = 1.
- Reset, which takes effect on the edge where `reset` = 1 regardless of `ce`:
  - all stage valid bits, `dout_valid`, `dout_sat` and `dout` go to 0;
  - `din_ready` is 1 in the first cycle after reset if `ce` = 1.
- Reset mid-operation discards all in-flight results. No partial output appears.
- While `dout_valid` = 1 and `dout_ready` = 0, `dout` and `dout_sat` hold stable, and `din_ready` = 0.
- `ce` = 0 holds every register, including valids. `din_ready` = 0.
- If `dout_ready` and `din_valid` are both 1 with a full pipeline, output and input transfer in the same cycle.

## Configuration
- Macro: `CASE_6_MUL_SAT_EN`.
- Defined:
  - Q is clamped to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1] when P is signed, else to [0, 2^dout_WIDTH-1].
  - `dout_sat` = 1 for results that were clamped.
- Undefined:
  - low-bit wrap;
  - `dout_sat` is constant 0;
  - no clamp comparators are synthesised.

## Structure
- Package `case_6_mul_pkg`:
  - product-width constant function;
  - min/max bound functions per signedness;
  - legal-range checks for NUM_STAGE and SHIFT.
- Sub-module `case_6_mul_narrow` is combinational: shift, clamp or wrap, and sat flag. It is instantiated once, in the last stage.
- Top level holds the stage registers, valid shift register and `adv` logic.

## Test plan
Test configuration unless stated: din0_WIDTH 11, din1_WIDTH 8, dout_WIDTH 11, NUM_STAGE 2, SHIFT 0, signed.
- Basic: 37 × 5, then −100 × 3 back-to-back with `dout_ready` = 1.
  - Required: 185 and −300 appear 2 cycles after each input, on consecutive cycles, with `dout_sat` = 0.
- Overflow: −1024 × −128.
  - Without macro: `dout` = 0, `dout_sat` = 0.
  - With macro: `dout` = 1023, `dout_sat` = 1.
- Shift: SHIFT = 4, 100 × 100.
  - Required: `dout` = 625.
  - Repeat with −7 × 1: `dout` = −1 (floor).
- Backpressure: stream 4 operand pairs and hold `dout_ready` = 0 for 3 cycles once `dout_valid` rises.
  - Required: `dout` is stable and `din_ready` = 0 during the hold.
  - On release, all 4 results arrive in order with none lost or duplicated.
- `ce` and reset:
  - Drop `ce` for 2 cycles mid-stream: outputs are delayed by exactly 2 cycles.
  - Assert `reset` with 2 results in flight: next cycle `dout_valid` = 0 and `dout` = 0, and no stale result emerges afterwards.
- Unsigned: SIGNED0 = SIGNED1 = 0, dout_WIDTH 19, 2047 × 255.
  - Required: `dout` = 521985.

Source files
------------

// File: rtl/case_6_mul_pkg.sv
// Shared widths, saturation bounds and parameter checks for the pipelined
// multiplier; the clamp option is selected by CASE_6_MUL_SAT_EN.
package case_6_mul_pkg;

  function automatic int prod_w(input int w0, input int w1);
    return w0 + w1;
  endfunction

  function automatic longint sat_max(input int w, input bit sgn);
    return sgn ? (64'sd1 <<< (w - 1)) - 64'sd1
               : (64'sd1 <<< w) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w, input bit sgn);
    return sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
  endfunction

  function automatic bit stages_ok(input int n);
    return (n >= 1) && (n <= 4);
  endfunction

  function automatic bit shift_ok(input int s, input int pw);
    return (s >= 0) && (s < pw);
  endfunction

  // Bounds are evaluated in 64-bit signed arithmetic.
  function automatic bit width_ok(input int pw, input int dw);
    return (pw + 1 <= 62) && (dw >= 1) && (dw <= 62);
  endfunction

endpackage

// File: rtl/case_6_mul_narrow.sv
// Last-stage shift and narrowing; clamps and flags when CASE_6_MUL_SAT_EN
// is defined, otherwise wraps to the low output bits.
module case_6_mul_narrow
  import case_6_mul_pkg::*;
#(
  parameter int PW    = 26,
  parameter int DW    = 26,
  parameter int SHIFT = 0,
  parameter bit PSGN  = 1'b1
) (
  input  logic [PW-1:0] p_i,
  output logic [DW-1:0] q_o,
  output logic          sat_o
);

  localparam int EW = (PW > DW) ? PW + 1 : DW + 1;

  logic signed [PW:0]   p_x;
  logic signed [PW:0]   q_x;
  logic signed [EW-1:0] q_e;

  // Extra top bit keeps unsigned products positive under >>>.
  assign p_x = $signed({PSGN & p_i[PW-1], p_i});
  assign q_x = p_x >>> SHIFT;
  assign q_e = EW'(q_x);

`ifdef CASE_6_MUL_SAT_EN
  localparam longint Hi = sat_max(DW, PSGN);
  localparam longint Lo = sat_min(DW, PSGN);

  logic signed [63:0] q_l;

  assign q_l = 64'(q_e);

  always_comb begin
    q_o   = q_e[DW-1:0];
    sat_o = 1'b0;
    if (q_l > Hi) begin
      q_o   = Hi[DW-1:0];
      sat_o = 1'b1;
    end else if (q_l < Lo) begin
      q_o   = Lo[DW-1:0];
      sat_o = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^q_e[EW-1:DW];
  assign q_o       = q_e[DW-1:0];
  assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/case_6_mul_pipe_sat.sv
// Pipelined signed/unsigned multiplier with valid/ready stall control;
// optional output saturation via CASE_6_MUL_SAT_EN.
module case_6_mul_pipe_sat
  import case_6_mul_pkg::*;
#(
  parameter int din0_WIDTH = 14,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 26,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_sat
);

  localparam int PW   = prod_w(din0_WIDTH, din1_WIDTH);
  localparam bit PSGN = (SIGNED0 != 0) || (SIGNED1 != 0);

  if (!stages_ok(NUM_STAGE)) begin : g_bad_stages
    $error("NUM_STAGE must be 1..4");
  end
  if (!shift_ok(SHIFT, PW)) begin : g_bad_shift
    $error("SHIFT out of range");
  end
  if (!width_ok(PW, dout_WIDTH)) begin : g_bad_width
    $error("widths too large");
  end

  logic                  adv;
  logic [NUM_STAGE-1:0]  v_q, v_d;
  logic [PW-1:0]         a_x, b_x, p_c, nar_in;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic                  sat_q, sat_d;

  if (SIGNED0 != 0) begin : g_a_s
    assign a_x = PW'($signed(din0));
  end else begin : g_a_u
    assign a_x = PW'(din0);
  end

  if (SIGNED1 != 0) begin : g_b_s
    assign b_x = PW'($signed(din1));
  end else begin : g_b_u
    assign b_x = PW'(din1);
  end

  // Low PW bits of the extended product are exact for every sign mix.
  assign p_c = a_x * b_x;

  assign adv       = ce & (~dout_valid | dout_ready);
  assign din_ready = adv;
  assign v_d       = (v_q << 1) | NUM_STAGE'(din_valid);

  if (NUM_STAGE == 1) begin : g_one
    assign nar_in = p_c;
  end else begin : g_pipe
    logic [PW-1:0] p_q [NUM_STAGE-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < NUM_STAGE - 1; i++) p_q[i] <= '0;
      end else if (adv) begin
        p_q[0] <= p_c;
        for (int i = 1; i < NUM_STAGE - 1; i++) p_q[i] <= p_q[i-1];
      end
    end

    assign nar_in = p_q[NUM_STAGE-2];
  end

  case_6_mul_narrow #(
    .PW   (PW),
    .DW   (dout_WIDTH),
    .SHIFT(SHIFT),
    .PSGN (PSGN)
  ) u_narrow (
    .p_i  (nar_in),
    .q_o  (dout_d),
    .sat_o(sat_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= '0;
      dout_q <= '0;
      sat_q  <= 1'b0;
    end else if (adv) begin
      v_q    <= v_d;
      dout_q <= dout_d;
      sat_q  <= sat_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = v_q[NUM_STAGE-1];
  assign dout_sat   = sat_q;

endmodule

// File: tb/tb_case_6_mul_pipe_sat.sv
// Directed bench for the pipelined multiplier: three configurations share
// one operand stream; expectations follow CASE_6_MUL_SAT_EN.
module tb_case_6_mul_pipe_sat;

  logic        clk;
  logic        reset;
  logic        ce;
  logic [10:0] din0;
  logic [7:0]  din1;
  logic        din_valid;
  logic        rdy;

  logic [10:0] a_dout, b_dout;
  logic [18:0] c_dout;
  logic        a_vld, b_vld, c_vld;
  logic        a_rdy, b_rdy, c_rdy;
  logic        a_sat, b_sat, c_sat;

  logic signed [31:0] a_s, b_s;
  logic        [31:0] c_u;
  logic signed [31:0] mon_q[$];

  int n_run;
  int n_fail;
  int seen;

  assign a_s = 32'($signed(a_dout));
  assign b_s = 32'($signed(b_dout));
  assign c_u = 32'(c_dout);

  case_6_mul_pipe_sat #(
    .din0_WIDTH(11), .din1_WIDTH(8), .dout_WIDTH(11),
    .NUM_STAGE(2), .SHIFT(0), .SIGNED0(1), .SIGNED1(1)
  ) u_a (
    .clk(clk), .reset(reset), .ce(ce),
    .din0(din0), .din1(din1),
    .din_valid(din_valid), .din_ready(a_rdy),
    .dout(a_dout), .dout_valid(a_vld),
    .dout_ready(rdy), .dout_sat(a_sat)
  );

  case_6_mul_pipe_sat #(
    .din0_WIDTH(11), .din1_WIDTH(8), .dout_WIDTH(11),
    .NUM_STAGE(2), .SHIFT(4), .SIGNED0(1), .SIGNED1(1)
  ) u_b (
    .clk(clk), .reset(reset), .ce(ce),
    .din0(din0), .din1(din1),
    .din_valid(din_valid), .din_ready(b_rdy),
    .dout(b_dout), .dout_valid(b_vld),
    .dout_ready(1'b1), .dout_sat(b_sat)
  );

  case_6_mul_pipe_sat #(
    .din0_WIDTH(11), .din1_WIDTH(8), .dout_WIDTH(19),
    .NUM_STAGE(2), .SHIFT(0), .SIGNED0(0), .SIGNED1(0)
  ) u_c (
    .clk(clk), .reset(reset), .ce(ce),
    .din0(din0), .din1(din1),
    .din_valid(din_valid), .din_ready(c_rdy),
    .dout(c_dout), .dout_valid(c_vld),
    .dout_ready(1'b1), .dout_sat(c_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record A's output transfers; inputs are stable from negedge to posedge.
  always @(negedge clk) begin
    if (!reset && ce && a_vld && rdy) mon_q.push_back(a_s);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input int b);
    din0      = 11'(a);
    din1      = 8'(b);
    din_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_rdy) break;
    end
    chk("push_rdy", 32'(a_rdy), 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_run     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    ce        = 1'b1;
    din0      = '0;
    din1      = '0;
    din_valid = 1'b0;
    rdy       = 1'b1;
    tick();
    tick();
    chk("rst_vld", 32'(a_vld), 0);
    chk("rst_dout", a_s, 0);
    chk("rst_sat", 32'(a_sat), 0);
    reset = 1'b0;
    #1;
    chk("rst_rdy_a", 32'(a_rdy), 1);
    chk("rst_rdy_b", 32'(b_rdy), 1);
    chk("rst_rdy_c", 32'(c_rdy), 1);

    // Back-to-back basic products
    push(37, 5);
    push(-100, 3);
    chk("basic0_vld", 32'(a_vld), 1);
    chk("basic0", a_s, 185);
    chk("basic0_sat", 32'(a_sat), 0);
    tick();
    chk("basic1_vld", 32'(a_vld), 1);
    chk("basic1", a_s, -300);
    chk("basic1_sat", 32'(a_sat), 0);
    tick();
    chk("basic_end", 32'(a_vld), 0);

    // Overflow and range edges
    push(-1024, -128);
    tick();
`ifdef CASE_6_MUL_SAT_EN
    chk("ovf_pos", a_s, 1023);
    chk("ovf_pos_sat", 32'(a_sat), 1);
`else
    chk("ovf_pos", a_s, 0);
    chk("ovf_pos_sat", 32'(a_sat), 0);
`endif
    push(-1024, 127);
    tick();
    chk("ovf_neg", a_s, -1024);
`ifdef CASE_6_MUL_SAT_EN
    chk("ovf_neg_sat", 32'(a_sat), 1);
`else
    chk("ovf_neg_sat", 32'(a_sat), 0);
`endif
    push(31, 33);
    push(-16, 64);
    chk("edge_max", a_s, 1023);
    chk("edge_max_sat", 32'(a_sat), 0);
    tick();
    chk("edge_min", a_s, -1024);
    chk("edge_min_sat", 32'(a_sat), 0);

    // Shifted configuration
    push(100, 100);
    push(-7, 1);
    chk("shift_vld", 32'(b_vld), 1);
    chk("shift_pos", b_s, 625);
    tick();
    chk("shift_floor", b_s, -1);
    chk("shift_sat", 32'(b_sat), 0);

    // Unsigned configuration
    push(2047, 255);
    tick();
    chk("uns_vld", 32'(c_vld), 1);
    chk("uns", c_u, 521985);
    chk("uns_sat", 32'(c_sat), 0);

    // Backpressure: stall three cycles once output goes valid
    tick();
    tick();
    tick();
    mon_q.delete();
    fork
      begin
        push(1, 2);
        push(3, 4);
        push(-5, 6);
        push(7, -8);
      end
      begin
        for (int n = 0; n < 20; n++) begin
          tick();
          if (a_vld) break;
        end
        chk("bp_rise", 32'(a_vld), 1);
        rdy = 1'b0;
        chk("bp_first", a_s, 2);
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold", a_s, 2);
          chk("bp_hold_vld", 32'(a_vld), 1);
          chk("bp_inrdy", 32'(a_rdy), 0);
        end
        tick();
        rdy = 1'b1;
      end
    join
    repeat (10) tick();
    chk("bp_cnt", mon_q.size(), 4);
    if (mon_q.size() == 4) begin
      chk("bp_ord0", mon_q[0], 2);
      chk("bp_ord1", mon_q[1], 12);
      chk("bp_ord2", mon_q[2], -30);
      chk("bp_ord3", mon_q[3], -56);
    end

    // Clock-enable drop delays the result by two cycles
    push(9, 9);
    ce = 1'b0;
    tick();
    tick();
    chk("ce_frozen_vld", 32'(a_vld), 0);
    chk("ce_frozen_rdy", 32'(a_rdy), 0);
    ce = 1'b1;
    tick();
    chk("ce_vld", 32'(a_vld), 1);
    chk("ce_dout", a_s, 81);

    // Reset with two results in flight
    tick();
    tick();
    push(10, 10);
    push(11, 11);
    chk("rst_pre", 32'(a_vld), 1);
    reset = 1'b1;
    mon_q.delete();
    tick();
    chk("rst_mid_vld", 32'(a_vld), 0);
    chk("rst_mid_dout", a_s, 0);
    chk("rst_mid_sat", 32'(a_sat), 0);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (a_vld) seen++;
    end
    chk("rst_stale", seen, 0);
    chk("rst_q", mon_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
